run_loader: RTL and testbench
=============================

Name: run_loader

Overview:
- Run sequencer that sits directly upstream of the processor core.
- On a `req` rising edge it holds the core in reset and preloads data memory from a valid/ready byte stream into consecutive addresses.
- It then releases the core and counts execution cycles until the core reports done or a cycle budget expires.
- It drives the data-memory write port while the core is held in reset, and it owns the system-level done/timeout status.

Parameters:
AW, 8, data memory address width (memory depth 2^AW bytes)
DW, 8, data word width
CW, 16, cycle counter and budget width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  start request; only a 0->1 edge starts a run
ld_count  input  AW+1  number of bytes to preload (0..2^AW); sampled on the start edge
max_cycles  input  CW  run budget in cycles; 0 = unlimited; sampled on the start edge
ld_valid  input  1  preload byte available
ld_data  input  DW  preload byte
ld_ready  output  1  loader accepts a byte this cycle
mem_wr_en  output  1  data memory write strobe
mem_addr  output  AW  data memory write address
mem_wr_data  output  DW  data memory write data
core_reset  output  1  holds core (PC, flags) in reset while high
core_done  input  1  core finished (program counter reached end)
busy  output  1  run in progress (LOAD, SETTLE or RUN)
done  output  1  sticky: run ended (normally or by timeout)
timeout  output  1  sticky: run ended by budget expiry
cycles  output  CW  RUN cycles elapsed, saturating

Behaviour:
- Reset (async, immediate, any state), required values:
  - state=IDLE.
  - ld_ready=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - core_reset=1, busy=0, done=0, timeout=0, cycles=0.
  - req edge-detect register=0, so `req` high at reset release counts as an edge.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE:
  - core_reset=1, ld_ready=0; done, timeout and cycles hold their last values.
  - On a req edge: latch ld_count and max_cycles; clear done, timeout and cycles; zero the write counter.
  - Go to LOAD if ld_count!=0, else go to SETTLE.
- LOAD:
  - ld_ready=1, driven combinationally from state.
  - Accept when ld_valid && ld_ready. Next cycle: mem_wr_en=1, mem_addr=write counter, mem_wr_data=ld_data (1-cycle registered latency); the write counter then increments.
  - On the accept whose count equals the latched ld_count, go to SETTLE. ld_ready is 0 from the next cycle.
  - mem_wr_en is 0 in any cycle with no accept in the prior cycle; ld_valid gaps are allowed.
  - With ld_count=2^AW, the last address is 2^AW-1 and the counter never wraps into a second pass.
- SETTLE:
  - Exactly 1 cycle; the final write pulse lands here. core_reset stays 1.
  - Then go to RUN.
- RUN:
  - core_reset=0 (registered, low from the first RUN cycle).
  - cycles increments every RUN cycle, including the first, and saturates at 2^CW-1.
  - If core_done=1: go to IDLE, set done=1, keep timeout=0.
  - Else if max_cycles!=0 and cycles+1==max_cycles in this cycle: go to IDLE, set done=1 and timeout=1. The final cycles value therefore equals max_cycles.
  - core_done and budget expiry in the same cycle: core_done wins, timeout=0.
- On entering IDLE from RUN, core_reset returns to 1 in the next cycle.
- busy=1 exactly while in LOAD, SETTLE or RUN.
- req edges in LOAD, SETTLE or RUN are ignored. req held high after completion does not restart; it must fall and rise again.
- ld_valid outside LOAD is ignored; no write occurs.
- mem_wr_en is never 1 while core_reset=0.
- ld_count/max_cycles changes after the start edge have no effect on the current run.

Test Plan:
1. ld_count=3, max_cycles=0, bytes A5,3C,7E with ld_valid held high, core_done asserted in the 10th RUN cycle -> three write pulses at addr 0,1,2 with data A5,3C,7E; core_reset falls one cycle after the last write; done=1, timeout=0, cycles=10, busy=0.
2. Same as 1 but ld_valid toggles 1,0,0,1,0,1 -> writes only after accepts; data order preserved; SETTLE follows the third accept.
3. ld_count=0 -> no mem_wr_en; IDLE→SETTLE→RUN; core_reset falls two cycles after the req edge.
4. max_cycles=5, core_done held 0 -> timeout=1, done=1, cycles=5, core_reset=1 the following cycle; core_done=1 in RUN cycle 5 with max_cycles=5 -> timeout=0, done=1.
5. Assert reset mid-LOAD after 2 of 4 bytes -> all outputs at reset values immediately; a fresh req edge with ld_count=4 restarts writes at addr 0.
6. req held high after completion -> no restart; req pulsed high during RUN -> ignored; ld_count=256 with AW=8 -> 256 writes, last mem_addr=FF, then SETTLE.

Source files
------------

// File: rtl/run_loader_if.sv
// Purpose: run_loader handshake/bus bundle (preload stream, memory write port,
//          core control and run status).
// Ports (signals):
//   req, ld_count, max_cycles      - run start request and per-run settings
//   ld_valid, ld_data, ld_ready    - preload byte stream (valid/ready)
//   mem_wr_en, mem_addr, mem_wr_data - data memory write port
//   core_reset, core_done          - core hold / completion
//   busy, done, timeout, cycles    - run status
// Modports: master = requester/environment side, slave = run_loader side.
interface run_loader_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
);
  logic          req;
  logic [AW:0]   ld_count;
  logic [CW-1:0] max_cycles;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          core_reset;
  logic          core_done;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  modport master (
    output req, ld_count, max_cycles, ld_valid, ld_data, core_done,
    input  ld_ready, mem_wr_en, mem_addr, mem_wr_data, core_reset,
           busy, done, timeout, cycles
  );

  modport slave (
    input  req, ld_count, max_cycles, ld_valid, ld_data, core_done,
    output ld_ready, mem_wr_en, mem_addr, mem_wr_data, core_reset,
           busy, done, timeout, cycles
  );
endinterface

// File: rtl/run_loader.sv
// Purpose: run sequencer in front of the processor core. A req rising edge
//          holds the core in reset, preloads data memory from a valid/ready
//          byte stream, settles one cycle, then releases the core and counts
//          run cycles until core_done or budget expiry.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - run_loader_if.slave (stream in, memory write port, core control,
//           busy/done/timeout/cycles status)
module run_loader #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic         clk,
  input  logic         reset,
  run_loader_if.slave  bus
);

  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW1  = CW + 1;
  localparam logic [CW-1:0] CYC_SAT = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_req_d;
  logic [AW:0]   r_ld_count;
  logic [CW-1:0] r_max_cycles;
  logic [AW:0]   r_wcnt;
  logic          r_mem_wr_en;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wr_data;
  logic          r_core_reset;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic [CW-1:0] r_cycles;

  logic          w_req_edge;
  logic          w_ld_ready;
  logic          w_accept;
  logic [AW:0]   w_wcnt_nxt;
  logic [CW-1:0] w_cycles_nxt;
  logic          w_budget_hit;

  assign w_req_edge   = bus.req & ~r_req_d;
  assign w_ld_ready   = (r_state == LOAD);
  assign w_accept     = bus.ld_valid & w_ld_ready;
  assign w_wcnt_nxt   = r_wcnt + CNTW'(1);
  assign w_cycles_nxt = (r_cycles == CYC_SAT) ? r_cycles : r_cycles + CW'(1);
  // Compare one bit wider so a saturated counter cannot alias to a small budget.
  assign w_budget_hit = (r_max_cycles != '0) &&
                        (({1'b0, r_cycles} + CW1'(1)) == {1'b0, r_max_cycles});

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_req_d       <= 1'b0;
      r_ld_count    <= '0;
      r_max_cycles  <= '0;
      r_wcnt        <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_core_reset  <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycles      <= '0;
    end else begin
      r_req_d     <= bus.req;
      r_mem_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_edge) begin
            r_ld_count   <= bus.ld_count;
            r_max_cycles <= bus.max_cycles;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycles     <= '0;
            r_wcnt       <= '0;
            r_busy       <= 1'b1;
            r_state      <= (bus.ld_count != '0) ? LOAD : SETTLE;
          end
        end
        LOAD: begin
          // Write lands one cycle after the accept; last accept moves to SETTLE.
          if (w_accept) begin
            r_mem_wr_en   <= 1'b1;
            r_mem_addr    <= r_wcnt[AW-1:0];
            r_mem_wr_data <= bus.ld_data;
            r_wcnt        <= w_wcnt_nxt;
            if (w_wcnt_nxt == r_ld_count) begin
              r_state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          r_core_reset <= 1'b0;
          r_state      <= RUN;
        end
        RUN: begin
          r_cycles <= w_cycles_nxt;
          if (bus.core_done) begin
            r_done       <= 1'b1;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
            r_core_reset <= 1'b1;
            r_state      <= IDLE;
          end else if (w_budget_hit) begin
            r_done       <= 1'b1;
            r_timeout    <= 1'b1;
            r_busy       <= 1'b0;
            r_core_reset <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ld_ready    = w_ld_ready;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wr_data = r_mem_wr_data;
  assign bus.core_reset  = r_core_reset;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.cycles      = r_cycles;

endmodule

// File: tb/tb_run_loader.sv
// Purpose: directed self-checking bench for run_loader (AW=8, DW=8, CW=16).
module tb_run_loader;

  logic clk;
  logic reset;

  run_loader_if #(.AW(8), .DW(8), .CW(16)) bus ();

  run_loader #(.AW(8), .DW(8), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [7:0] src [0:255];
  bit         vpat [$];
  logic [7:0] wa_q [$];
  logic [7:0] wd_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write pulse; flag any write while the core is running.
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wr_data);
      if (bus.core_reset !== 1'b1) viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int cnt, input int mc);
    bus.ld_count   = 9'(cnt);
    bus.max_cycles = 16'(mc);
    bus.req        = 1'b1;
    step(1);
    bus.req        = 1'b0;
  endtask

  // Feed n bytes from src[] following the cyclic valid pattern vpat.
  task automatic load_bytes(input int n, output int got);
    int   idx;
    int   k;
    logic acc;
    idx = 0;
    k   = 0;
    while (idx < n && k < 4000) begin
      bus.ld_data  = src[idx];
      bus.ld_valid = vpat[k % vpat.size()];
      acc = bus.ld_valid & bus.ld_ready;
      step(1);
      if (acc) idx++;
      k++;
    end
    bus.ld_valid = 1'b0;
    got = idx;
  endtask

  task automatic finish_core;
    bus.core_done = 1'b1;
    step(1);
    bus.core_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req = 1'b1;
    bus.ld_count = 9'd0;
    bus.max_cycles = 16'd0;
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'd0;
    bus.core_done = 1'b0;
    step(2);
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready got=%0h exp=0", bus.ld_ready); end
    total++; if (bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_mem_wr_en got=%0h exp=0", bus.mem_wr_en); end
    total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 8'h00) begin bad++; $display("FAIL rst_mem_wr_data got=%0h exp=0", bus.mem_wr_data); end
    total++; if (bus.core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%0h exp=1", bus.core_reset); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", bus.done); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0h exp=0", bus.timeout); end
    total++; if (bus.cycles !== 16'd0) begin bad++; $display("FAIL rst_cycles got=%0d exp=0", bus.cycles); end
    // req already high when reset releases counts as a start edge.
    reset = 1'b0;
    step(1);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_req_edge_busy got=%0h exp=1", bus.busy); end
    step(1);
    total++; if (bus.core_reset !== 1'b0) begin bad++; $display("FAIL rst_req_edge_run got=%0h exp=0", bus.core_reset); end
    finish_core();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rst_run_done got=%0h exp=1", bus.done); end
    total++; if (bus.cycles !== 16'd1) begin bad++; $display("FAIL rst_run_cycles got=%0d exp=1", bus.cycles); end
    bus.req = 1'b0;
    step(2);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done_sticky got=%0h exp=1", bus.done); end
  endtask

  task automatic test_basic_load;
    int got;
    wa_q.delete(); wd_q.delete();
    src[0] = 8'hA5; src[1] = 8'h3C; src[2] = 8'h7E;
    vpat.delete(); vpat.push_back(1'b1);
    start_run(3, 0);
    total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL basic_ld_ready got=%0h exp=1", bus.ld_ready); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_clear got=%0h exp=0", bus.done); end
    load_bytes(3, got);
    total++; if (got !== 3) begin bad++; $display("FAIL basic_accepts got=%0d exp=3", got); end
    total++; if (bus.mem_wr_en !== 1'b1) begin bad++; $display("FAIL basic_settle_wr got=%0h exp=1", bus.mem_wr_en); end
    total++; if (bus.mem_addr !== 8'h02) begin bad++; $display("FAIL basic_settle_addr got=%0h exp=2", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 8'h7E) begin bad++; $display("FAIL basic_settle_data got=%0h exp=7e", bus.mem_wr_data); end
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL basic_settle_ready got=%0h exp=0", bus.ld_ready); end
    total++; if (bus.core_reset !== 1'b1) begin bad++; $display("FAIL basic_settle_core_reset got=%0h exp=1", bus.core_reset); end
    step(1);
    total++; if (bus.core_reset !== 1'b0) begin bad++; $display("FAIL basic_run_core_reset got=%0h exp=0", bus.core_reset); end
    total++; if (bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL basic_run_wr got=%0h exp=0", bus.mem_wr_en); end
    step(9);
    total++; if (bus.cycles !== 16'd9) begin bad++; $display("FAIL basic_cycles_mid got=%0d exp=9", bus.cycles); end
    finish_core();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0h exp=1", bus.done); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0h exp=0", bus.timeout); end
    total++; if (bus.cycles !== 16'd10) begin bad++; $display("FAIL basic_cycles got=%0d exp=10", bus.cycles); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0h exp=0", bus.busy); end
    total++; if (bus.core_reset !== 1'b1) begin bad++; $display("FAIL basic_core_reset_back got=%0h exp=1", bus.core_reset); end
    total++; if (wa_q.size() !== 3) begin bad++; $display("FAIL basic_nwrites got=%0d exp=3", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 3; i++) begin
      total++; if (wa_q[i] !== 8'(i) || wd_q[i] !== src[i]) begin bad++; $display("FAIL basic_write%0d got=%0h/%0h exp=%0h/%0h", i, wa_q[i], wd_q[i], i, src[i]); end
    end
    step(1);
  endtask

  task automatic test_valid_gaps;
    int got;
    wa_q.delete(); wd_q.delete();
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    vpat.delete();
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0);
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b1);
    start_run(3, 0);
    load_bytes(3, got);
    total++; if (got !== 3) begin bad++; $display("FAIL gaps_accepts got=%0d exp=3", got); end
    total++; if (bus.mem_wr_en !== 1'b1 || bus.ld_ready !== 1'b0) begin bad++; $display("FAIL gaps_settle got=wr%0h/rdy%0h exp=wr1/rdy0", bus.mem_wr_en, bus.ld_ready); end
    step(1);
    total++; if (bus.core_reset !== 1'b0) begin bad++; $display("FAIL gaps_run got=%0h exp=0", bus.core_reset); end
    finish_core();
    total++; if (wa_q.size() !== 3) begin bad++; $display("FAIL gaps_nwrites got=%0d exp=3", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 3; i++) begin
      total++; if (wa_q[i] !== 8'(i) || wd_q[i] !== src[i]) begin bad++; $display("FAIL gaps_write%0d got=%0h/%0h exp=%0h/%0h", i, wa_q[i], wd_q[i], i, src[i]); end
    end
    step(1);
  endtask

  task automatic test_zero_count;
    wa_q.delete(); wd_q.delete();
    start_run(0, 0);
    total++; if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b0 || bus.core_reset !== 1'b1) begin bad++; $display("FAIL zero_settle got=busy%0h/rdy%0h/cr%0h exp=1/0/1", bus.busy, bus.ld_ready, bus.core_reset); end
    step(1);
    total++; if (bus.core_reset !== 1'b0) begin bad++; $display("FAIL zero_core_reset got=%0h exp=0", bus.core_reset); end
    finish_core();
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", wa_q.size()); end
    step(1);
  endtask

  task automatic test_timeout;
    start_run(0, 5);
    total++; if (bus.done !== 1'b0 || bus.cycles !== 16'd0) begin bad++; $display("FAIL to_clear got=done%0h/cyc%0d exp=0/0", bus.done, bus.cycles); end
    step(5);
    total++; if (bus.done !== 1'b0 || bus.cycles !== 16'd4) begin bad++; $display("FAIL to_mid got=done%0h/cyc%0d exp=0/4", bus.done, bus.cycles); end
    step(1);
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_timeout got=%0h exp=1", bus.timeout); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL to_done got=%0h exp=1", bus.done); end
    total++; if (bus.cycles !== 16'd5) begin bad++; $display("FAIL to_cycles got=%0d exp=5", bus.cycles); end
    total++; if (bus.core_reset !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL to_end got=cr%0h/busy%0h exp=1/0", bus.core_reset, bus.busy); end
    step(1);
    // core_done on the budget cycle wins over timeout.
    start_run(0, 5);
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_clear2 got=%0h exp=0", bus.timeout); end
    step(5);
    finish_core();
    total++; if (bus.timeout !== 1'b0 || bus.done !== 1'b1 || bus.cycles !== 16'd5) begin bad++; $display("FAIL to_tie got=to%0h/done%0h/cyc%0d exp=0/1/5", bus.timeout, bus.done, bus.cycles); end
    step(1);
  endtask

  task automatic test_reset_mid_load;
    int got;
    src[0] = 8'hC1; src[1] = 8'hC2; src[2] = 8'hC3; src[3] = 8'hC4;
    vpat.delete(); vpat.push_back(1'b1);
    start_run(4, 0);
    load_bytes(2, got);
    total++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 8'h01) begin bad++; $display("FAIL mid_second_write got=wr%0h/addr%0h exp=1/1", bus.mem_wr_en, bus.mem_addr); end
    reset = 1'b1;
    #1;
    total++; if (bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 8'h00) begin bad++; $display("FAIL mid_rst_mem got=%0h/%0h/%0h exp=0/0/0", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data); end
    total++; if (bus.ld_ready !== 1'b0 || bus.busy !== 1'b0 || bus.core_reset !== 1'b1) begin bad++; $display("FAIL mid_rst_ctl got=rdy%0h/busy%0h/cr%0h exp=0/0/1", bus.ld_ready, bus.busy, bus.core_reset); end
    total++; if (bus.done !== 1'b0 || bus.timeout !== 1'b0 || bus.cycles !== 16'd0) begin bad++; $display("FAIL mid_rst_status got=%0h/%0h/%0d exp=0/0/0", bus.done, bus.timeout, bus.cycles); end
    step(1);
    reset = 1'b0;
    step(1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_idle_after_rst got=%0h exp=0", bus.busy); end
    wa_q.delete(); wd_q.delete();
    start_run(4, 0);
    load_bytes(4, got);
    total++; if (got !== 4) begin bad++; $display("FAIL mid_restart_accepts got=%0d exp=4", got); end
    step(1);
    finish_core();
    total++; if (wa_q.size() !== 4) begin bad++; $display("FAIL mid_restart_nwrites got=%0d exp=4", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 4; i++) begin
      total++; if (wa_q[i] !== 8'(i) || wd_q[i] !== src[i]) begin bad++; $display("FAIL mid_write%0d got=%0h/%0h exp=%0h/%0h", i, wa_q[i], wd_q[i], i, src[i]); end
    end
    step(1);
  endtask

  task automatic test_req_rules;
    // req held high through completion must not restart.
    bus.ld_count = 9'd0;
    bus.max_cycles = 16'd0;
    bus.req = 1'b1;
    step(2);
    finish_core();
    step(3);
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin bad++; $display("FAIL req_held got=busy%0h/done%0h exp=0/1", bus.busy, bus.done); end
    bus.req = 1'b0;
    step(1);
    // req pulses, stray ld_valid and setting changes during RUN are ignored.
    wa_q.delete(); wd_q.delete();
    start_run(0, 0);
    bus.ld_valid = 1'b1;
    step(1);
    bus.max_cycles = 16'd2;
    bus.req = 1'b1; step(1);
    bus.req = 1'b0; step(1);
    bus.req = 1'b1; step(1);
    bus.req = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.cycles !== 16'd3 || bus.core_reset !== 1'b0) begin bad++; $display("FAIL req_in_run got=busy%0h/cyc%0d/cr%0h exp=1/3/0", bus.busy, bus.cycles, bus.core_reset); end
    finish_core();
    bus.ld_valid = 1'b0;
    total++; if (bus.cycles !== 16'd4 || bus.timeout !== 1'b0) begin bad++; $display("FAIL req_run_end got=cyc%0d/to%0h exp=4/0", bus.cycles, bus.timeout); end
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL stray_valid_writes got=%0d exp=0", wa_q.size()); end
    step(1);
  endtask

  task automatic test_full_depth;
    int got;
    int errs;
    for (int i = 0; i < 256; i++) src[i] = 8'(i) ^ 8'h5A;
    vpat.delete(); vpat.push_back(1'b1);
    wa_q.delete(); wd_q.delete();
    start_run(256, 0);
    load_bytes(256, got);
    total++; if (got !== 256) begin bad++; $display("FAIL full_accepts got=%0d exp=256", got); end
    total++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 8'hFF || bus.ld_ready !== 1'b0) begin bad++; $display("FAIL full_last got=wr%0h/addr%0h/rdy%0h exp=1/ff/0", bus.mem_wr_en, bus.mem_addr, bus.ld_ready); end
    bus.ld_valid = 1'b1;
    step(1);
    total++; if (bus.core_reset !== 1'b0 || bus.mem_wr_en !== 1'b0) begin bad++; $display("FAIL full_run got=cr%0h/wr%0h exp=0/0", bus.core_reset, bus.mem_wr_en); end
    bus.ld_valid = 1'b0;
    finish_core();
    total++; if (wa_q.size() !== 256) begin bad++; $display("FAIL full_nwrites got=%0d exp=256", wa_q.size()); end
    errs = 0;
    for (int i = 0; i < wa_q.size() && i < 256; i++) begin
      if (wa_q[i] !== 8'(i) || wd_q[i] !== (8'(i) ^ 8'h5A)) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL full_contents got=%0d bad entries exp=0", errs); end
    step(1);
  endtask

  task automatic test_no_write_in_run;
    total++; if (viol !== 0) begin bad++; $display("FAIL write_while_running got=%0d exp=0", viol); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b0;
    bus.ld_count = 9'd0;
    bus.max_cycles = 16'd0;
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'd0;
    bus.core_done = 1'b0;
    test_reset();
    test_basic_load();
    test_valid_gaps();
    test_zero_count();
    test_timeout();
    test_reset_mid_load();
    test_req_rules();
    test_full_depth();
    test_no_write_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
